data_ram_sync: RTL



---
 rtl/mem_pkg.sv | 37 +++
 rtl/ram_byte_array.sv | 35 +++
 rtl/data_ram_sync.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the synchronous data memory: access-size codes,
// FSM state encoding, latched request record and the alignment rule.
package mem_pkg;

  localparam logic [1:0] DT_BYTE = 2'b00;
  localparam logic [1:0] DT_HALF = 2'b01;
  localparam logic [1:0] DT_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } state_t;

  // Request fields captured at the accepting edge (address kept separately
  // because its width is a parameter of the top module).
  typedef struct packed {
    logic        rw;
    logic [1:0]  dt;
    logic        sx;
    logic [31:0] wdata;
  } req_t;

  // True when the access size and the low address bits do not form a legal
  // aligned access; the illegal size code always faults.
  function automatic logic misaligned(input logic [1:0] dt, input logic [1:0] a_lo);
    logic bad;
    unique case (dt)
      DT_BYTE: bad = 1'b0;
      DT_HALF: bad = a_lo[0];
      DT_WORD: bad = (a_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ram_byte_array.sv
// Byte-wide storage with four lanes; each lane has one address used both for
// its combinational read and its clocked write.
module ram_byte_array
  import mem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                   clk,
  input  logic [3:0]             we,
  input  logic [3:0][ADDR_W-1:0] addr,
  input  logic [3:0][7:0]        wdata,
  output logic [3:0][7:0]        rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [7:0] mem [DEPTH];

  // Lane writes; the top only enables lanes with distinct addresses.
  // NOTE: the array has no reset branch on purpose -- contents are undefined
  // until written, and a reset loop over every byte would not map to RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr[i]] <= wdata[i];
    end
  end

  // Asynchronous read of every lane, consumed at the completion edge.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rdata[i] = mem[addr[i]];
    end
  end

endmodule

// File: rtl/data_ram_sync.sv
// Synchronous byte-addressed big-endian data memory with a fixed number of
// wait states, an enable/done handshake and alignment fault reporting.
module data_ram_sync
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              rw,
  input  logic [1:0]        dataType,
  input  logic              signExt,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       dataIn,
  output logic [31:0]       dataOut,
  output logic              done,
  output logic              busy,
  output logic              err
);

  // Counter start value; unused when there are no wait states.
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t                 state, state_nxt;
  logic [3:0]             cnt;
  req_t                   req;
  logic [ADDR_W-1:0]      req_addr;
  logic                   accept, finish, fault;
  logic [3:0]             lane_we;
  logic [3:0][ADDR_W-1:0] lane_addr;
  logic [3:0][7:0]        lane_wdata, lane_rdata;
  logic [31:0]            rd_value;

  assign accept = (state == IDLE) && enable;
  assign finish = (state == DONE);
  assign fault  = misaligned(req.dt, req_addr[1:0]);

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  // NOTE: every variable written here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (enable) state_nxt = (WAIT_CYCLES == 0) ? DONE : WAIT;
      WAIT:    if (cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Wait-state counter, loaded on accept and run down while waiting.
  always_ff @(posedge clk) begin
    if (!rst_n)                         cnt <= 4'd0;
    else if (accept)                    cnt <= CNT_INIT;
    else if (state == WAIT && cnt != 0) cnt <= cnt - 4'd1;
  end

  // Request latch; only read after an accept, so it needs no reset value.
  always_ff @(posedge clk) begin
    if (accept) begin
      req.rw    <= rw;
      req.dt    <= dataType;
      req.sx    <= signExt;
      req.wdata <= dataIn;
      req_addr  <= address;
    end
  end

  // Lane steering: lane i addresses A+i and carries the i-th byte counted
  // from the most significant end of the access.
  always_comb begin
    lane_we    = 4'b0000;
    lane_wdata = '0;
    for (int i = 0; i < 4; i++) begin
      lane_addr[i] = req_addr + ADDR_W'(i);
    end
    unique case (req.dt)
      DT_BYTE: begin
        lane_wdata[0] = req.wdata[7:0];
        lane_we       = 4'b0001;
      end
      DT_HALF: begin
        lane_wdata[0] = req.wdata[15:8];
        lane_wdata[1] = req.wdata[7:0];
        lane_we       = 4'b0011;
      end
      DT_WORD: begin
        lane_wdata[0] = req.wdata[31:24];
        lane_wdata[1] = req.wdata[23:16];
        lane_wdata[2] = req.wdata[15:8];
        lane_wdata[3] = req.wdata[7:0];
        lane_we       = 4'b1111;
      end
      default: lane_we = 4'b0000;
    endcase
    // Writes only land at a clean completion edge outside reset.
    if (!(finish && req.rw && !fault && rst_n)) lane_we = 4'b0000;
  end

  // Read assembly with zero or sign extension for sub-word sizes.
  always_comb begin
    rd_value = '0;
    unique case (req.dt)
      DT_BYTE: begin
        rd_value = {24'h0, lane_rdata[0]};
        if (req.sx && lane_rdata[0][7]) rd_value[31:8] = 24'hFFFFFF;
      end
      DT_HALF: begin
        rd_value = {16'h0, lane_rdata[0], lane_rdata[1]};
        if (req.sx && lane_rdata[0][7]) rd_value[31:16] = 16'hFFFF;
      end
      default: rd_value = {lane_rdata[0], lane_rdata[1], lane_rdata[2], lane_rdata[3]};
    endcase
  end

  // Handshake outputs and read-data register; dataOut moves only on a
  // successful read completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dataOut <= 32'h0;
      done    <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= finish;
      err  <= finish && fault;
      if (accept)      busy <= 1'b1;
      else if (finish) busy <= 1'b0;
      if (finish && !fault && !req.rw) dataOut <= rd_value;
    end
  end

  ram_byte_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .we    (lane_we),
    .addr  (lane_addr),
    .wdata (lane_wdata),
    .rdata (lane_rdata)
  );

endmodule
